// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: mult/div op encoding, the zero register and default unit latencies.
package pipeline_pkg;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned DEFAULT_MULT_CYCLES = 4;
    localparam int unsigned DEFAULT_DIV_CYCLES  = 32;

    // Encoding 11 is reserved and behaves like no operation.
    function automatic logic is_muldiv(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_tracker.sv
// Occupancy tracker for the multi-cycle mult/div unit: accepts a start, then counts busy cycles down to zero.
module muldiv_tracker
    import pipeline_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic       branch_taken,
    input  logic       stall,
    output logic       start,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

    logic [CNT_W-1:0] md_cnt;
    logic             accept;

    // A squashed or stalled op must not launch; an in-flight op is never aborted by a branch.
    assign accept = !reset && is_muldiv(op) && !branch_taken && !stall && (md_cnt == '0);
    assign start  = accept;
    assign busy   = (md_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (accept) begin
            md_cnt <= (op == MD_MULT) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage core: load-use / HI-LO / RAW stalls, branch and jump squashes, stall counter.
// Define HAZARD_STALL_ONLY_EN for cores without EX/MEM forwarding (register RAW dependencies then stall).
module hazard_control_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_UsesRs,
    input  logic        ID_UsesRt,
    input  logic        ID_UsesHiLo,
    input  logic [1:0]  ID_MulDivOp,
    input  logic        ID_Jump,
    input  logic        EX_MemRead,
    input  logic        EX_RegWrite,
    input  logic [4:0]  EX_rd,
    input  logic        MEM_RegWrite,
    input  logic [4:0]  MEM_rd,
    input  logic        EX_BranchTaken,
    output logic        PCWrite,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Bubble,
    output logic        MulDivStart,
    output logic        MulDivBusy,
    output logic [31:0] StallCount
);

    logic load_use;
    logic hilo_hz;
    logic raw_extra;
    logic stall;

    function automatic logic use_hit(input logic [4:0] r, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic uses_rs, input logic uses_rt);
        return (r != REG_ZERO) && ((uses_rs && (rs == r)) || (uses_rt && (rt == r)));
    endfunction

    assign load_use = EX_MemRead && use_hit(EX_rd, ID_rs, ID_rt, ID_UsesRs, ID_UsesRt);
    assign hilo_hz  = MulDivBusy && (ID_UsesHiLo || is_muldiv(ID_MulDivOp));

`ifdef HAZARD_STALL_ONLY_EN
    // Without forwarding, wait until the producer reaches WB (write-first register file covers WB).
    assign raw_extra = (EX_RegWrite  && use_hit(EX_rd,  ID_rs, ID_rt, ID_UsesRs, ID_UsesRt)) ||
                       (MEM_RegWrite && use_hit(MEM_rd, ID_rs, ID_rt, ID_UsesRs, ID_UsesRt));
`else
    logic raw_unused;
    assign raw_unused = ^{EX_RegWrite, MEM_RegWrite, MEM_rd};
    assign raw_extra  = 1'b0;
`endif

    assign stall = load_use || hilo_hz || raw_extra;

    muldiv_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_muldiv_tracker (
        .clk          (Clk),
        .reset        (Reset),
        .op           (ID_MulDivOp),
        .branch_taken (EX_BranchTaken),
        .stall        (stall),
        .start        (MulDivStart),
        .busy         (MulDivBusy)
    );

    // Priority: reset, taken branch, stall, jump, normal flow.
    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        if (Reset) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
        end else if (EX_BranchTaken) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
        end else if (stall) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end else if (ID_Jump) begin
            IFID_Flush  = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            StallCount <= '0;
        end else if (!PCWrite && (StallCount != 32'hFFFF_FFFF)) begin
            StallCount <= StallCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed hazard scenarios plus randomized traffic against a rule-level model.
module tb_hazard_control_unit;

    localparam int unsigned MULT_N = 4;
    localparam int unsigned DIV_N  = 32;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  ID_rs, ID_rt, EX_rd, MEM_rd;
    logic        ID_UsesRs, ID_UsesRt, ID_UsesHiLo, ID_Jump;
    logic [1:0]  ID_MulDivOp;
    logic        EX_MemRead, EX_RegWrite, MEM_RegWrite, EX_BranchTaken;
    logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, MulDivStart, MulDivBusy;
    logic [31:0] StallCount;

    int          n_vectors = 0;
    int          n_miscompares = 0;

    // Reference state: cycles of mult/div occupancy left and stall cycles seen
    int          ref_busy_left = 0;
    longint      ref_stalls = 0;

    hazard_control_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .Clk(Clk), .Reset(Reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_UsesHiLo(ID_UsesHiLo), .ID_MulDivOp(ID_MulDivOp), .ID_Jump(ID_Jump),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_rd(EX_rd),
        .MEM_RegWrite(MEM_RegWrite), .MEM_rd(MEM_rd), .EX_BranchTaken(EX_BranchTaken),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Bubble(IDEX_Bubble), .MulDivStart(MulDivStart), .MulDivBusy(MulDivBusy),
        .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit reads(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        return (ID_UsesRs && ID_rs == r) || (ID_UsesRt && ID_rt == r);
    endfunction

    task automatic clear_inputs();
        ID_rs = '0; ID_rt = '0; ID_UsesRs = 0; ID_UsesRt = 0; ID_UsesHiLo = 0;
        ID_MulDivOp = 2'b00; ID_Jump = 0; EX_MemRead = 0; EX_RegWrite = 0; EX_rd = '0;
        MEM_RegWrite = 0; MEM_rd = '0; EX_BranchTaken = 0;
    endtask

    // Check one cycle at the falling edge, advance the model, then move past the rising edge.
    task automatic step();
        bit busy, md, stl, start;
        bit e_pc, e_ifw, e_fl, e_bub;
        @(negedge Clk);
        busy = (ref_busy_left > 0);
        md   = (ID_MulDivOp == 2'd1) || (ID_MulDivOp == 2'd2);
        stl  = (EX_MemRead && reads(EX_rd)) || (busy && (ID_UsesHiLo || md));
`ifdef HAZARD_STALL_ONLY_EN
        stl  = stl || (EX_RegWrite && reads(EX_rd)) || (MEM_RegWrite && reads(MEM_rd));
`endif
        if (Reset)               {e_pc, e_ifw, e_fl, e_bub} = 4'b0011;
        else if (EX_BranchTaken) {e_pc, e_ifw, e_fl, e_bub} = 4'b1111;
        else if (stl)            {e_pc, e_ifw, e_fl, e_bub} = 4'b0001;
        else if (ID_Jump)        {e_pc, e_ifw, e_fl, e_bub} = 4'b1110;
        else                     {e_pc, e_ifw, e_fl, e_bub} = 4'b1100;
        start = !Reset && md && !EX_BranchTaken && !stl && !busy;

        check_val("PCWrite",     32'(PCWrite),     32'(e_pc));
        check_val("IFID_Write",  32'(IFID_Write),  32'(e_ifw));
        check_val("IFID_Flush",  32'(IFID_Flush),  32'(e_fl));
        check_val("IDEX_Bubble", 32'(IDEX_Bubble), 32'(e_bub));
        check_val("MulDivStart", 32'(MulDivStart), 32'(start));
        check_val("MulDivBusy",  32'(MulDivBusy),  32'(busy));
        check_val("StallCount",  StallCount,       32'(ref_stalls));

        if (Reset) begin
            ref_busy_left = 0;
            ref_stalls    = 0;
        end else begin
            if (start)                  ref_busy_left = (ID_MulDivOp == 2'd1) ? MULT_N : DIV_N;
            else if (ref_busy_left > 0) ref_busy_left--;
            if (!e_pc && ref_stalls < 64'hFFFF_FFFF) ref_stalls++;
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        step();
        step();
        check_val("reset_cnt",  StallCount, 32'd0);
        check_val("reset_busy", 32'(MulDivBusy), 32'd0);
        Reset = 1'b0;

        // Load-use on $1, then the load has moved on
        EX_MemRead = 1; EX_rd = 5'd1; ID_UsesRs = 1; ID_rs = 5'd1;
        step();
        clear_inputs();
        step();
        check_val("lu_cnt", StallCount, 32'd1);

        // $0 never hazards
        EX_MemRead = 1; EX_rd = 5'd0; ID_UsesRs = 1; ID_rs = 5'd0;
        step();
        check_val("zero_cnt", StallCount, 32'd1);

        // Taken branch overrides a load-use stall
        EX_MemRead = 1; EX_rd = 5'd2; ID_UsesRt = 1; ID_rt = 5'd2; EX_BranchTaken = 1;
        step();
        clear_inputs();
        check_val("br_cnt", StallCount, 32'd1);

        ID_Jump = 1;
        step();
        clear_inputs();

        // div then dependent mfhi: 32 stall cycles, issued on the 33rd
        ID_MulDivOp = 2'b10;
        step();
        ID_MulDivOp = 2'b00; ID_UsesHiLo = 1;
        for (int i = 0; i < 33; i++) step();
        check_val("div_cnt", StallCount, 32'd33);
        check_val("div_busy", 32'(MulDivBusy), 32'd0);
        clear_inputs();

        // Reset two cycles after mult start
        ID_MulDivOp = 2'b01;
        step();
        clear_inputs();
        step();
        step();
        Reset = 1;
        step();
        Reset = 0;
        check_val("rst_mid_busy", 32'(MulDivBusy), 32'd0);
        check_val("rst_mid_cnt",  StallCount, 32'd0);

        // MEM-stage producer of rt (stalls only without forwarding)
        MEM_RegWrite = 1; MEM_rd = 5'd3; ID_UsesRt = 1; ID_rt = 5'd3;
        step();
        clear_inputs();
        step();

        for (int i = 0; i < 3000; i++) begin
            Reset          = ($urandom_range(63) == 0);
            ID_rs          = 5'($urandom_range(3));
            ID_rt          = 5'($urandom_range(3));
            EX_rd          = 5'($urandom_range(3));
            MEM_rd         = 5'($urandom_range(3));
            ID_UsesRs      = 1'($urandom);
            ID_UsesRt      = 1'($urandom);
            ID_UsesHiLo    = ($urandom_range(3) == 0);
            ID_MulDivOp    = 2'($urandom);
            ID_Jump        = ($urandom_range(7) == 0);
            EX_MemRead     = ($urandom_range(3) == 0);
            EX_RegWrite    = 1'($urandom);
            MEM_RegWrite   = 1'($urandom);
            EX_BranchTaken = ($urandom_range(7) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the 5-stage MIPS core, driven by the InstructionDecodePhase. It detects load-use and register RAW hazards and stalls or squashes the IF/ID and ID/EX registers. It also tracks occupancy of the multi-cycle mult/div unit and issues its start pulse. A saturating stall counter is exposed for performance debug.

## Interface
- MULT_CYCLES, 4: mult busy cycles after start.
- DIV_CYCLES, 32: div busy cycles after start; must be ≥ MULT_CYCLES.
- Clk  in  1  sole clock, rising edge.
- Reset  in  1  synchronous, active-high.
- ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
- ID_UsesRs, ID_UsesRt  in  1 each  instruction in ID actually reads rs/rt.
- ID_UsesHiLo  in  1  instruction in ID reads HI/LO (mfhi, mflo).
- ID_MulDivOp  in  2  00 none, 01 mult, 10 div, 11 reserved (treated as none).
- ID_Jump  in  1  j/jal in ID.
- EX_MemRead, EX_RegWrite  in  1 each  load / register write in EX.
- EX_rd  in  5  destination register in EX.
- MEM_RegWrite  in  1  register write in MEM.
- MEM_rd  in  5  destination register in MEM.
- EX_BranchTaken  in  1  branch or jr resolved taken in EX.
- PCWrite  out  1  PC update enable.
- IFID_Write  out  1  IF/ID load enable.
- IFID_Flush  out  1  IF/ID cleared to nop on next edge.
- IDEX_Bubble  out  1  ID/EX control cleared to nop on next edge.
- MulDivStart  out  1  one-cycle start pulse to mult/div unit.
- MulDivBusy  out  1  mult/div counter non-zero.
- StallCount  out  32  cycles with PCWrite=0 since reset; saturates at 0xFFFFFFFF.

## Operation
- Internal state: busy counter `md_cnt` (width $clog2(DIV_CYCLES+1)); stall counter.
  - Mode RUN when md_cnt == 0; mode MDBUSY otherwise.
- Register $0 never creates a hazard.
- `use_hit(r)` = (ID_UsesRs & ID_rs == r) | (ID_UsesRt & ID_rt == r), with r ≠ 0.
- `load_use` = EX_MemRead & use_hit(EX_rd).
- `hilo_hz` = MulDivBusy & (ID_UsesHiLo | ID_MulDivOp ∈ {01, 10}).
- `stall` = load_use | hilo_hz | raw_extra. raw_extra is defined under Configuration.
- Output priority, highest first:
  1. EX_BranchTaken: PCWrite=1, IFID_Write=1, IFID_Flush=1, IDEX_Bubble=1. Overrides any stall; the ID instruction is squashed.
  2. stall: PCWrite=0, IFID_Write=0, IFID_Flush=0, IDEX_Bubble=1.
  3. ID_Jump: PCWrite=1, IFID_Write=1, IFID_Flush=1, IDEX_Bubble=0.
  4. Otherwise: PCWrite=1, IFID_Write=1, both clears 0.
- Mult/div start is accepted when ID_MulDivOp ∈ {01, 10}, !EX_BranchTaken, !stall and md_cnt == 0.
  - On accept, MulDivStart=1 that cycle and md_cnt loads MULT_CYCLES or DIV_CYCLES.
  - Otherwise md_cnt decrements toward 0 each cycle.
- A taken branch does not abort a mult/div already in flight; it belongs to an older instruction.
- StallCount increments by 1 on each edge where PCWrite=0 and Reset=0, saturating at 0xFFFFFFFF.

## Timing
- All hazard and control outputs are combinational from inputs and registered state, valid in the same cycle.
- Only md_cnt and StallCount are registered.
- While Reset=1: PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1, MulDivStart=0.
- After the reset edge: md_cnt=0, MulDivBusy=0, StallCount=0.
- Load-use stall lasts exactly 1 cycle; the next cycle the load has moved to MEM.
- Mult/div started at edge N: MulDivBusy=1 for edges N+1 through N+k (k = op cycles), 0 at N+k+1.
  - A dependent mfhi is released in the first cycle MulDivBusy=0.
- Reset asserted mid-operation: md_cnt and StallCount clear on that edge; no start pulse is issued.
- Stall and branch in the same cycle: branch wins; StallCount does not increment.

## Configuration
- HAZARD_STALL_ONLY_EN undefined: the EX/MEM forwarding unit is present and raw_extra = 0.
- HAZARD_STALL_ONLY_EN defined: no forwarding, and raw_extra = (EX_RegWrite & use_hit(EX_rd)) | (MEM_RegWrite & use_hit(MEM_rd)).
  - Each such dependency stalls until the producer reaches WB; the register file writes first half, reads second half.

## Structure
- Shared `pipeline_pkg` holds:
  - MulDivOp encoding constants (MD_NONE, MD_MULT, MD_DIV);
  - REG_ZERO;
  - default MULT_CYCLES/DIV_CYCLES values.
- One sub-module, `muldiv_tracker`: owns md_cnt, the accept logic, MulDivStart and MulDivBusy.
- The top level holds the hazard compares, output priority mux and StallCount.

## Test plan
- Load-use: EX lw $1 (EX_MemRead=1, EX_rd=1) with ID add reading rs=1 -> one cycle PCWrite=0, IFID_Write=0, IDEX_Bubble=1, then normal; StallCount=1.
- $0 filter: EX_MemRead=1, EX_rd=0, ID_rs=0 -> no stall; PCWrite=1.
- Branch over stall: EX_BranchTaken=1 together with the load-use condition -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1; StallCount unchanged.
- Div then mfhi: ID_MulDivOp=10 -> MulDivStart pulse, MulDivBusy high 32 cycles. mfhi held in ID for those cycles (StallCount=32), issued in cycle 33.
- Jump: ID_Jump=1, no hazard -> IFID_Flush=1, IDEX_Bubble=0, PCWrite=1.
- Reset mid-mult: Reset asserted 2 cycles after mult start -> MulDivBusy=0 and StallCount=0 after that edge. With HAZARD_STALL_ONLY_EN defined, MEM_RegWrite=1, MEM_rd=3 and ID_rt=3 -> 1-cycle stall.
